// File: rtl/regfile_wb_sched_pkg.sv
// Shared definitions for the register-file write-back scheduler: FSM states,
// requester indices and fixed register numbers.
package regfile_wb_sched_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int NUM_REQ = 3;
  localparam int REQ_ALU = 0;
  localparam int REQ_LD  = 1;
  localparam int REQ_LNK = 2;

  localparam logic [4:0] REG_ZERO     = 5'h00;
  localparam logic [4:0] LINK_REG_DEF = 5'h1F;

  // Next requester index in round-robin order ALU -> LD -> LNK -> ALU.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    case (idx)
      2'd0:    rr_next = 2'd1;
      2'd1:    rr_next = 2'd2;
      default: rr_next = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] g);
    case (g)
      3'b010:  onehot_idx = 2'(REQ_LD);
      3'b100:  onehot_idx = 2'(REQ_LNK);
      default: onehot_idx = 2'(REQ_ALU);
    endcase
  endfunction

endpackage

// File: rtl/regfile_wb_sched_rr_arbiter3.sv
// Combinational 3-way round-robin arbiter; the search starts one past the
// last-grant pointer, which is owned by the caller.
module rr_arbiter3
  import regfile_wb_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [1:0] order [NUM_REQ];
  logic       found;

  always_comb begin
    order[0] = rr_next(ptr_i);
    order[1] = rr_next(order[0]);
    order[2] = rr_next(order[1]);
  end

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_i[order[k]]) begin
        grant_o[order[k]] = 1'b1;
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file write-port scheduler: zeroes all registers after reset, then
// round-robins the single write port between ALU, load and link write-back.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] LINK_REG = ADDR_W'(LINK_REG_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_req,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_gnt,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_gnt,
  input  logic              lnk_req,
  input  logic [DATA_W-1:0] lnk_data,
  output logic              lnk_gnt,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_busy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                sweep_done_q, sweep_done_d;
  logic [1:0]          ptr_q, ptr_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                init_busy_q, init_busy_d;

  logic [NUM_REQ-1:0]  req_elig;
  logic [NUM_REQ-1:0]  grant;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // A requester granted last cycle is still holding its (now served) request.
  assign req_elig = {lnk_req, ld_req, alu_req} & ~gnt_q;

  rr_arbiter3 u_arb (
    .req_i   (req_elig),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  always_comb begin
    sel_addr = alu_addr;
    sel_data = alu_data;
    if (grant[REQ_LD]) begin
      sel_addr = ld_addr;
      sel_data = ld_data;
    end
    if (grant[REQ_LNK]) begin
      sel_addr = LINK_REG;
      sel_data = lnk_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sweep_done_d = sweep_done_q;
    ptr_d        = ptr_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    gnt_d        = '0;
    init_busy_d  = init_busy_q;

    case (state_q)
      ST_INIT: begin
        // One idle cycle after the last sweep write so init_busy drops with rf_we low.
        if (sweep_done_q) begin
          state_d      = ST_RUN;
          sweep_done_d = 1'b0;
          init_busy_d  = 1'b0;
        end else begin
          rf_we_d     = 1'b1;
          rf_waddr_d  = cnt_q;
          rf_wdata_d  = '0;
          cnt_d       = cnt_q + ADDR_W'(1);
          init_busy_d = 1'b1;
          if (cnt_q == '1) begin
            sweep_done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        init_busy_d = 1'b0;
        if (|grant) begin
          gnt_d      = grant;
          ptr_d      = onehot_idx(grant);
          rf_waddr_d = sel_addr;
          rf_wdata_d = sel_data;
          rf_we_d    = (sel_addr != ADDR_W'(REG_ZERO));
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      sweep_done_q <= 1'b0;
      ptr_q        <= 2'(REQ_LNK);
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      gnt_q        <= '0;
      init_busy_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sweep_done_q <= sweep_done_d;
      ptr_q        <= ptr_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      gnt_q        <= gnt_d;
      init_busy_q  <= init_busy_d;
    end
  end

  assign alu_gnt   = gnt_q[REQ_ALU];
  assign ld_gnt    = gnt_q[REQ_LD];
  assign lnk_gnt   = gnt_q[REQ_LNK];
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign init_busy = init_busy_q;

endmodule
